weighted_pixel_neuron: RTL and testbench

// - Time-multiplexed binary neuron. Visits the HEIGHT binary pixels one after another, one window each.
// - In each window an active pixel is turned into a unit-pulse stream whose count encodes its signed weight.
// - The pulses of one frame are summed into a balance counter. At frame end the block publishes the total
//   and a fire decision.
// - Internals: stimulus generator, rate-multiplier divider (x2: neg/pos path), 1-cycle delay on pos path,

---
 rtl/weighted_pixel_neuron_if.sv | 14 +
 rtl/weighted_pixel_neuron.sv | 167 ++++++++++++++++
 tb/tb_weighted_pixel_neuron.sv | 128 ++++++++++++
 3 files changed

// File: rtl/weighted_pixel_neuron_if.sv
// Pixel/result bundle of the weighted pixel neuron.
// The master drives the binary pixels; the slave (the neuron) returns the
// frame total and the fire decision.
interface weighted_pixel_neuron_if #(
  parameter int HEIGHT = 7,
  parameter int BW     = 11
);
  logic [HEIGHT-1:0] pixels;
  logic              neuron_out;
  logic [BW-1:0]     balance_out;

  modport master (output pixels, input neuron_out, input balance_out);
  modport slave  (input pixels, output neuron_out, output balance_out);
endinterface

// File: rtl/weighted_pixel_neuron.sv
// Time-multiplexed binary neuron.
// Each pixel owns one window of L = 2**(WIDTH+1)+2 clocks. Inside the window a
// stimulus of 2**WIDTH pulses drives a rate-multiplier divider. The divider's
// carries are delayed by one clock on positive pixels and inverted against the
// stimulus on negative pixels. The resulting pulses are summed over a frame,
// and at frame end the total and the fire decision are published.
module weighted_pixel_neuron #(
  parameter int         WIDTH           = 8,
  parameter int         HEIGHT          = 7,
  parameter int         NUM_POS_WEIGHTS = 3,
  parameter logic [WIDTH:0] WEIGHTS [0:HEIGHT-1] =
    '{9'd60, 9'd60, 9'd60, 9'd260, 9'd260, 9'd260, 9'd260}
) (
  input  logic                    clk,
  input  logic                    rst,
  weighted_pixel_neuron_if.slave  bus
);

  // Counts the weights whose sign bit marks them negative.
  function automatic int count_neg();
    int n;
    n = 0;
    for (int i = 0; i < HEIGHT; i++) begin
      n += int'(WEIGHTS[i][WIDTH]);
    end
    return n;
  endfunction

  // One rate-multiplier step: {carry, new accumulator}.
  function automatic logic [WIDTH:0] div_step(input logic [WIDTH-1:0] acc,
                                              input logic [WIDTH-1:0] w);
    return {1'b0, acc} + {1'b0, w};
  endfunction

  localparam int L   = 2 ** (WIDTH + 1) + 2;
  localparam int CW  = $clog2(L);
  localparam int IW  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int BW  = $clog2(HEIGHT * (2 ** WIDTH) + 1);
  // NUM_POS_WEIGHTS is carried for compatibility only; the sign bits of
  // WEIGHTS alone decide which pixels are negative.
  localparam int NUM_NEG = count_neg() + 0 * NUM_POS_WEIGHTS;

  localparam logic [CW-1:0] CNT_LAST  = CW'(L - 1);
  localparam logic [CW-1:0] STIM_LAST = CW'(2 ** (WIDTH + 1));
  localparam logic [IW-1:0] IDX_LAST  = IW'(HEIGHT - 1);
  localparam logic [BW-1:0] THR       = BW'(NUM_NEG * (2 ** WIDTH));

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    pixel_idx_q, pixel_idx_d;
  logic [WIDTH-1:0] acc_neg_q, acc_neg_d;
  logic [WIDTH-1:0] acc_pos_q, acc_pos_d;
  logic             dly_q, dly_d;
  logic [BW-1:0]    sum_q, sum_d;
  logic             neuron_out_q, neuron_out_d;
  logic [BW-1:0]    balance_out_q, balance_out_d;

  logic             sign_s;
  logic [WIDTH-1:0] mag_s;
  logic             stim_s;
  logic             pulse_s;
  logic [WIDTH:0]   neg_step_s;
  logic [WIDTH:0]   pos_step_s;
  logic             neg_div_out_s;
  logic             pos_div_out_s;
  logic             pixel_out_s;
  logic             frame_end_s;
  logic [BW-1:0]    sum_total_s;

  // Current pixel's weight, stimulus pulse and divider carries.
  always_comb begin
    sign_s        = WEIGHTS[pixel_idx_q][WIDTH];
    mag_s         = WEIGHTS[pixel_idx_q][WIDTH-1:0];
    stim_s        = (cnt_q >= CW'(2)) && !cnt_q[0] && (cnt_q <= STIM_LAST);
    pulse_s       = stim_s & bus.pixels[pixel_idx_q];
    neg_step_s    = div_step(acc_neg_q, mag_s);
    pos_step_s    = div_step(acc_pos_q, mag_s);
    neg_div_out_s = pulse_s & sign_s & neg_step_s[WIDTH];
    pos_div_out_s = pulse_s & ~sign_s & pos_step_s[WIDTH];
    // Negative pixels emit a pulse wherever the stimulus produced no carry.
    if (sign_s) begin
      pixel_out_s = stim_s & ~neg_div_out_s;
    end else begin
      pixel_out_s = dly_q;
    end
    frame_end_s = (cnt_q == CNT_LAST) && (pixel_idx_q == IDX_LAST);
  end

  // Window counter and pixel selector.
  always_comb begin
    cnt_d       = cnt_q + CW'(1);
    pixel_idx_d = pixel_idx_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      if (pixel_idx_q == IDX_LAST) begin
        pixel_idx_d = '0;
      end else begin
        pixel_idx_d = pixel_idx_q + IW'(1);
      end
    end else begin
      pixel_idx_d = pixel_idx_q;
    end
  end

  // Divider accumulators and positive-path delay, cleared at window start.
  always_comb begin
    acc_neg_d = acc_neg_q;
    acc_pos_d = acc_pos_q;
    dly_d     = pos_div_out_s;
    if (cnt_q == '0) begin
      acc_neg_d = '0;
      acc_pos_d = '0;
      dly_d     = 1'b0;
    end else if (pulse_s && sign_s) begin
      acc_neg_d = neg_step_s[WIDTH-1:0];
    end else if (pulse_s) begin
      acc_pos_d = pos_step_s[WIDTH-1:0];
    end else begin
      acc_neg_d = acc_neg_q;
    end
  end

  // Frame accumulator; publishes total and fire decision at frame end.
  always_comb begin
    balance_out_d = balance_out_q;
    neuron_out_d  = neuron_out_q;
    if (cnt_q >= CW'(2)) begin
      sum_total_s = sum_q + BW'(pixel_out_s);
    end else begin
      sum_total_s = sum_q;
    end
    sum_d = sum_total_s;
    if (frame_end_s) begin
      balance_out_d = sum_total_s;
      neuron_out_d  = (sum_total_s > THR);
      sum_d         = '0;
    end else begin
      sum_d = sum_total_s;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q         <= '0;
      pixel_idx_q   <= '0;
      acc_neg_q     <= '0;
      acc_pos_q     <= '0;
      dly_q         <= 1'b0;
      sum_q         <= '0;
      neuron_out_q  <= 1'b0;
      balance_out_q <= '0;
    end else begin
      cnt_q         <= cnt_d;
      pixel_idx_q   <= pixel_idx_d;
      acc_neg_q     <= acc_neg_d;
      acc_pos_q     <= acc_pos_d;
      dly_q         <= dly_d;
      sum_q         <= sum_d;
      neuron_out_q  <= neuron_out_d;
      balance_out_q <= balance_out_d;
    end
  end

  assign bus.neuron_out  = neuron_out_q;
  assign bus.balance_out = balance_out_q;

endmodule

// File: tb/tb_weighted_pixel_neuron.sv
// Self-checking bench for weighted_pixel_neuron: directed frames from the
// block description, a mid-frame reset, and random pixel frames, all checked
// against a frame-level arithmetic model.
module tb_weighted_pixel_neuron;

  localparam int WIDTH  = 8;
  localparam int HEIGHT = 7;
  localparam int BW     = 11;
  localparam int L      = 514;
  localparam int FRAME  = HEIGHT * L;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  int   prev_bal;
  logic prev_fire;

  weighted_pixel_neuron_if #(.HEIGHT(HEIGHT), .BW(BW)) bus ();

  weighted_pixel_neuron dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame total from the weight rules: positive pixels contribute w when
  // active, negative pixels contribute 256 minus (w when active).
  function automatic int model_total(input logic [HEIGHT-1:0] pix);
    int weights [HEIGHT] = '{60, 60, 60, 260, 260, 260, 260};
    int total;
    int mag;
    total = 0;
    for (int i = 0; i < HEIGHT; i++) begin
      mag = weights[i] % 256;
      if (weights[i] >= 256) total += 256 - (pix[i] ? mag : 0);
      else                   total += (pix[i] ? mag : 0);
    end
    return total;
  endfunction

  function automatic int model_thr();
    int weights [HEIGHT] = '{60, 60, 60, 260, 260, 260, 260};
    int n;
    n = 0;
    for (int i = 0; i < HEIGHT; i++) if (weights[i] >= 256) n++;
    return n * 256;
  endfunction

  task automatic check_int(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Runs one full frame with constant pixels; checks hold mid-frame and the
  // update on the frame-end clock.
  task automatic run_frame(input logic [HEIGHT-1:0] pix, input string tag);
    int exp_bal;
    logic exp_fire;
    bus.pixels = pix;
    exp_bal  = model_total(pix);
    exp_fire = (exp_bal > model_thr());
    for (int k = 1; k < FRAME; k++) begin
      @(posedge clk); #1;
      if (k == FRAME / 2 || k == FRAME - 1) begin
        check_int({tag, "_hold_bal"}, int'(bus.balance_out), prev_bal);
        check_int({tag, "_hold_fire"}, int'(bus.neuron_out), int'(prev_fire));
      end
    end
    @(posedge clk); #1;
    check_int({tag, "_bal"}, int'(bus.balance_out), exp_bal);
    check_int({tag, "_fire"}, int'(bus.neuron_out), int'(exp_fire));
    prev_bal  = exp_bal;
    prev_fire = exp_fire;
  endtask

  initial begin
    logic [HEIGHT-1:0] rpix;
    vectors     = 0;
    miscompares = 0;
    prev_bal    = 0;
    prev_fire   = 1'b0;
    rst         = 1'b0;
    bus.pixels  = 7'b0000000;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_int("reset_bal", int'(bus.balance_out), 0);
    check_int("reset_fire", int'(bus.neuron_out), 0);
    rst = 1'b1;

    // Directed frames
    run_frame(7'b0000000, "all_off");
    run_frame(7'b0001110, "bits123");
    run_frame(7'b1111000, "neg_on");
    run_frame(7'b0000001, "bit0");

    // Mid-frame reset discards the partial frame
    bus.pixels = 7'b1010101;
    repeat (1000) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_int("midrst_bal", int'(bus.balance_out), 0);
    check_int("midrst_fire", int'(bus.neuron_out), 0);
    rst       = 1'b1;
    prev_bal  = 0;
    prev_fire = 1'b0;
    run_frame(7'b0001110, "after_rst");

    // Random frames
    for (int f = 0; f < 6; f++) begin
      rpix = 7'($urandom_range(0, 127));
      run_frame(rpix, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
